// File: rtl/screen_writer.sv
// -----------------------------------------------------------------------------
// screen_writer
// Turns character-terminal commands into writes on a circular character
// buffer of ROWS*COLS bytes. The screen is scrolled by moving the scroll
// origin (first_char) forward one row instead of copying memory, so every
// logical (row, col) is mapped to a physical address relative to that origin.
//
// Optional feature macro: SCREEN_WRITER_CLEAR_EOS_EN
//   defined   -> cmd 2 clears from (row, col) to the end of the screen
//   undefined -> cmd 2 is accepted and discarded
//
// Ports
//   clk              : single clock
//   reset            : asynchronous, active-low reset
//   cmd              : 0=PUT, 1=CLEAR_EOL, 2=CLEAR_EOS, 3=SCROLL
//   cmd_row/cmd_col  : logical target position, sampled at acceptance only
//   cmd_char         : byte written by PUT
//   cmd_valid        : command offered
//   cmd_ready        : high in IDLE; command accepted on cmd_valid & cmd_ready
//   new_char         : char buffer write data
//   new_char_address : char buffer write address
//   new_char_wen     : char buffer write strobe
//   first_char       : current scroll origin (physical address of row 0 col 0)
//   first_char_wen   : one-cycle pulse when first_char changes
//   busy             : high while a multi-cycle operation runs
// -----------------------------------------------------------------------------
module screen_writer #(
  parameter int         ROWS      = 24,
  parameter int         COLS      = 80,
  parameter int         ROW_BITS  = 5,
  parameter int         COL_BITS  = 7,
  parameter int         ADDR_BITS = 11,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           cmd,
  input  logic [ROW_BITS-1:0]  cmd_row,
  input  logic [COL_BITS-1:0]  cmd_col,
  input  logic [7:0]           cmd_char,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen,
  output logic [ADDR_BITS-1:0] first_char,
  output logic                 first_char_wen,
  output logic                 busy
);

  // One extra bit so origin + offset never overflows before the modulo.
  typedef logic [ADDR_BITS:0] wide_t;

  localparam wide_t TOTAL_W  = wide_t'(ROWS * COLS);
  localparam wide_t COLS_W   = wide_t'(COLS);
  localparam wide_t BOTTOM_W = wide_t'((ROWS - 1) * COLS);
  localparam logic [ROW_BITS:0] ROWS_L = (ROW_BITS + 1)'(ROWS);
  localparam logic [COL_BITS:0] COLS_L = (COL_BITS + 1)'(COLS);

  localparam logic [1:0] CMD_PUT       = 2'd0;
  localparam logic [1:0] CMD_CLEAR_EOL = 2'd1;
  localparam logic [1:0] CMD_CLEAR_EOS = 2'd2;
  localparam logic [1:0] CMD_SCROLL    = 2'd3;

  typedef enum logic [1:0] {IDLE, FILL, SCROLL} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] first_char_next;
  logic [ADDR_BITS-1:0] fill_addr, fill_addr_next;
  wide_t                remaining, remaining_next;
  logic [7:0]           new_char_next;
  logic [ADDR_BITS-1:0] new_char_address_next;
  logic                 new_char_wen_next;
  logic                 first_char_wen_next;

  wide_t                offset;
  logic                 in_range;
  logic [ADDR_BITS-1:0] cmd_addr;

  // Both operands are below ROWS*COLS, so a single conditional subtract
  // performs the modulo.
  function automatic logic [ADDR_BITS-1:0] wrap_add(input logic [ADDR_BITS-1:0] base,
                                                    input wide_t offs);
    wide_t sum;
    sum = {1'b0, base} + offs;
    if (sum >= TOTAL_W) sum = sum - TOTAL_W;
    return ADDR_BITS'(sum);
  endfunction

  assign offset    = wide_t'(cmd_row) * COLS_W + wide_t'(cmd_col);
  assign in_range  = ({1'b0, cmd_row} < ROWS_L) && ({1'b0, cmd_col} < COLS_L);
  assign cmd_addr  = wrap_add(first_char, offset);
  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;

  // Register bank: FSM state plus all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      first_char       <= '0;
      fill_addr        <= '0;
      remaining        <= '0;
      new_char         <= '0;
      new_char_address <= '0;
      new_char_wen     <= 1'b0;
      first_char_wen   <= 1'b0;
    end else begin
      state            <= state_next;
      first_char       <= first_char_next;
      fill_addr        <= fill_addr_next;
      remaining        <= remaining_next;
      new_char         <= new_char_next;
      new_char_address <= new_char_address_next;
      new_char_wen     <= new_char_wen_next;
      first_char_wen   <= first_char_wen_next;
    end
  end

  // Next-state logic. A fill issues its first write on the transition into
  // FILL; 'remaining' then counts the writes still to come after the one
  // currently on the outputs, and fill_addr holds the address of the next.
  always_comb begin
    state_next            = state;
    first_char_next       = first_char;
    fill_addr_next        = fill_addr;
    remaining_next        = remaining;
    new_char_next         = new_char;
    new_char_address_next = new_char_address;
    new_char_wen_next     = 1'b0;
    first_char_wen_next   = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && in_range) begin
          case (cmd)
            CMD_PUT: begin
              new_char_wen_next     = 1'b1;
              new_char_next         = cmd_char;
              new_char_address_next = cmd_addr;
            end
            CMD_CLEAR_EOL: begin
              new_char_wen_next     = 1'b1;
              new_char_next         = FILL_CHAR;
              new_char_address_next = cmd_addr;
              fill_addr_next        = wrap_add(cmd_addr, wide_t'(1));
              remaining_next        = wide_t'(COLS - 1) - wide_t'(cmd_col);
              state_next            = FILL;
            end
            CMD_CLEAR_EOS: begin
`ifdef SCREEN_WRITER_CLEAR_EOS_EN
              new_char_wen_next     = 1'b1;
              new_char_next         = FILL_CHAR;
              new_char_address_next = cmd_addr;
              fill_addr_next        = wrap_add(cmd_addr, wide_t'(1));
              remaining_next        = TOTAL_W - offset - wide_t'(1);
              state_next            = FILL;
`endif
            end
            CMD_SCROLL: begin
              first_char_next     = wrap_add(first_char, COLS_W);
              first_char_wen_next = 1'b1;
              state_next          = SCROLL;
            end
            default: ;
          endcase
        end
      end

      // first_char already holds the new origin here, so the bottom row
      // is addressed relative to it.
      SCROLL: begin
        new_char_wen_next     = 1'b1;
        new_char_next         = FILL_CHAR;
        new_char_address_next = wrap_add(first_char, BOTTOM_W);
        fill_addr_next        = wrap_add(first_char, BOTTOM_W + wide_t'(1));
        remaining_next        = COLS_W - wide_t'(1);
        state_next            = FILL;
      end

      FILL: begin
        if (remaining == '0) begin
          state_next = IDLE;
        end else begin
          new_char_wen_next     = 1'b1;
          new_char_next         = FILL_CHAR;
          new_char_address_next = fill_addr;
          fill_addr_next        = wrap_add(fill_addr, wide_t'(1));
          remaining_next        = remaining - wide_t'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_screen_writer.sv
// -----------------------------------------------------------------------------
// tb_screen_writer
// Scoreboard bench for screen_writer. At acceptance the reference model
// expands each command into the list of (cycle, address, data) writes and
// scroll-origin updates it must produce; a monitor on the falling edge pops
// and compares them as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_screen_writer;

  localparam int ROWS  = 24;
  localparam int COLS  = 80;
  localparam int TOTAL = ROWS * COLS;
  localparam int FILLV = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd = '0;
  logic [4:0]  cmd_row = '0;
  logic [6:0]  cmd_col = '0;
  logic [7:0]  cmd_char = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  new_char;
  logic [10:0] new_char_address;
  logic        new_char_wen;
  logic [10:0] first_char;
  logic        first_char_wen;
  logic        busy;

  screen_writer dut (
    .clk              (clk),
    .reset            (reset),
    .cmd              (cmd),
    .cmd_row          (cmd_row),
    .cmd_col          (cmd_col),
    .cmd_char         (cmd_char),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .new_char         (new_char),
    .new_char_address (new_char_address),
    .new_char_wen     (new_char_wen),
    .first_char       (first_char),
    .first_char_wen   (first_char_wen),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cycle;
    int addr;
    int data;
  } event_t;

  event_t wr_q[$];
  event_t fc_q[$];

  int model_fc    = 0;
  int busy_until  = -1;
  int vectors     = 0;
  int miscompares = 0;
  int writes_seen = 0;
  bit mon_en      = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: a command at logical offset row*COLS+col touches
  // physical (origin + offset) mod ROWS*COLS, one write per cycle.
  task automatic predict(input int c, input int row, input int col, input int ch, input int n);
    int base;
    int last;
    if (row >= ROWS || col >= COLS) return;
    base = row * COLS + col;
    case (c)
      0: wr_q.push_back('{n + 1, (model_fc + base) % TOTAL, ch});
      1, 2: begin
        last = row * COLS + COLS - 1;
        if (c == 2) begin
`ifdef SCREEN_WRITER_CLEAR_EOS_EN
          last = TOTAL - 1;
`else
          return;
`endif
        end
        for (int off = base; off <= last; off++)
          wr_q.push_back('{n + 1 + off - base, (model_fc + off) % TOTAL, FILLV});
        busy_until = n + last - base + 1;
      end
      default: begin
        model_fc = (model_fc + COLS) % TOTAL;
        fc_q.push_back('{n + 1, model_fc, 0});
        for (int i = 0; i < COLS; i++)
          wr_q.push_back('{n + 2 + i, (model_fc + (ROWS - 1) * COLS + i) % TOTAL, FILLV});
        busy_until = n + COLS + 1;
      end
    endcase
  endtask

  // Monitor: runs on the falling edge, before the driver moves at +1.
  always @(negedge clk) begin
    event_t e;
    if (mon_en) begin
      checkOutput("cmd_ready", int'(cmd_ready), int'(cyc > busy_until));
      checkOutput("busy", int'(busy), int'(cyc <= busy_until));
      checkOutput("wen_overlap", int'(new_char_wen & first_char_wen), 0);

      if (new_char_wen) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_write_addr", int'(new_char_address), -1);
        end else begin
          e = wr_q.pop_front();
          checkOutput("write_cycle", cyc, e.cycle);
          checkOutput("write_addr", int'(new_char_address), e.addr);
          checkOutput("write_data", int'(new_char), e.data);
          writes_seen++;
        end
      end else if (wr_q.size() > 0 && wr_q[0].cycle <= cyc) begin
        e = wr_q.pop_front();
        checkOutput("missing_write_addr", -1, e.addr);
      end

      if (first_char_wen) begin
        if (fc_q.size() == 0) begin
          checkOutput("unexpected_first_char", int'(first_char), -1);
        end else begin
          e = fc_q.pop_front();
          checkOutput("first_char_cycle", cyc, e.cycle);
          checkOutput("first_char_value", int'(first_char), e.addr);
        end
      end else if (fc_q.size() > 0 && fc_q[0].cycle <= cyc) begin
        e = fc_q.pop_front();
        checkOutput("missing_first_char", -1, e.addr);
      end
    end
  end

  // Offers one command; while the DUT is busy the inputs carry random
  // garbage (sometimes with cmd_valid high), which must be ignored.
  task automatic applyStimulus(input int c, input int row, input int col, input int ch);
    int waited = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      #1;
      if (cmd_ready) begin
        cmd       = 2'(c);
        cmd_row   = 5'(row);
        cmd_col   = 7'(col);
        cmd_char  = 8'(ch);
        cmd_valid = 1'b1;
        predict(c, row, col, ch, cyc);
        done = 1'b1;
      end else begin
        cmd       = 2'($urandom_range(0, 3));
        cmd_row   = 5'($urandom_range(0, 31));
        cmd_col   = 7'($urandom_range(0, 127));
        cmd_char  = 8'($urandom_range(0, 255));
        cmd_valid = 1'($urandom_range(0, 1));
        waited++;
        if (waited > 3000) begin
          checkOutput("ready_timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    idleCycle();
    while ((wr_q.size() != 0 || fc_q.size() != 0 || cyc <= busy_until) && waited < 3000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("drain_timeout", int'(waited >= 3000), 0);
  endtask

  initial begin
    int base;
    int waited;
    int c;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_new_char_wen", int'(new_char_wen), 0);
    checkOutput("reset_first_char_wen", int'(first_char_wen), 0);
    checkOutput("reset_new_char", int'(new_char), 0);
    checkOutput("reset_new_char_address", int'(new_char_address), 0);
    checkOutput("reset_first_char", int'(first_char), 0);
    checkOutput("reset_busy", int'(busy), 0);
    reset = 1'b1;
    mon_en = 1'b1;
    checkOutput("release_ready", int'(cmd_ready), 1);

    // PUT at the origin, then a short end-of-line clear (237..239).
    applyStimulus(0, 0, 0, 8'h41);
    applyStimulus(1, 2, 77, 0);
    drain();

    // Out-of-range commands and CLEAR_EOS near the bottom.
    applyStimulus(0, 24, 0, 8'h55);
    applyStimulus(1, 0, 80, 0);
    applyStimulus(3, 25, 3, 0);
    applyStimulus(2, 23, 70, 0);
    drain();

    // Back-to-back PUTs sustain one write per cycle.
    for (int i = 0; i < 6; i++) applyStimulus(0, i, 79 - i, 8'h30 + i);
    drain();

    // 23 scrolls bring the origin to 1840; the 24th wraps it to 0 and
    // clears 1840..1919; the 25th clears a bottom row starting at 0.
    for (int i = 0; i < 25; i++) applyStimulus(3, 0, 0, 0);
    drain();
    checkOutput("first_char_after_scrolls", int'(first_char), model_fc);

    // Randomized traffic, including out-of-range positions.
    for (int i = 0; i < 120; i++) begin
      c = $urandom_range(0, 9);
      if (c <= 4) c = 0;
      else if (c <= 6) c = 1;
      else if (c == 7) c = 2;
      else c = 3;
      applyStimulus(c, $urandom_range(0, 25), $urandom_range(0, 81), $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    drain();
    checkOutput("first_char_after_random", int'(first_char), model_fc);

    // Reset in the middle of a long fill.
    base = writes_seen;
`ifdef SCREEN_WRITER_CLEAR_EOS_EN
    applyStimulus(2, 0, 0, 0);
`else
    applyStimulus(1, 0, 0, 0);
`endif
    idleCycle();
    waited = 0;
    while (writes_seen < base + 10 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("fill_progress_timeout", int'(waited >= 200), 0);
    reset = 1'b0;
    wr_q.delete();
    fc_q.delete();
    model_fc = 0;
    busy_until = cyc;
    #1;
    checkOutput("abort_new_char_wen", int'(new_char_wen), 0);
    checkOutput("abort_first_char", int'(first_char), 0);
    checkOutput("abort_new_char_address", int'(new_char_address), 0);
    checkOutput("abort_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    checkOutput("abort_release_ready", int'(cmd_ready), 1);
    checkOutput("abort_release_first_char", int'(first_char), 0);

    applyStimulus(0, 5, 3, 8'h5A);
    drain();
    checkOutput("final_first_char", int'(first_char), model_fc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
